// File: rtl/ssl_pkg.sv
// ssl_pkg: shared definitions for the ssl_match comparator.
// Holds the default word width, the distance-width helper, the FSM state
// encoding and the codes reported on the best output.
package ssl_pkg;

    localparam int NDATA_DEF = 128;

    // Width needed to hold a count in the range 0..n inclusive.
    function automatic int DIST_W(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

endpackage

// File: rtl/ssl_popcnt.sv
// ssl_popcnt: combinational population count of a W-bit chunk.
module ssl_popcnt
    import ssl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]           bits,
    output logic [DIST_W(W)-1:0]   count
);

    localparam int CW = DIST_W(W);

    // Sum the set bits of the chunk.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/ssl_match.sv
// ssl_match: multi-cycle Hamming-distance comparator.
// Snapshots a reference word and three signatures, scans them NCHUNK bits
// per enabled cycle, and reports per-signature distances, the closest
// signature (ties favour A, then B) and a threshold match.
// Optional feature macro: SSL_MATCH_VOTE_EN adds doutVote (bitwise 2-of-3
// majority of A/B/C) and voteFix (its distance from the reference).
module ssl_match
    import ssl_pkg::*;
#(
    parameter int NDATA  = NDATA_DEF,
    parameter int NCHUNK = 8,
    parameter int THRESH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        start,
    input  logic [NDATA-1:0]            doutRef,
    input  logic [NDATA-1:0]            doutSigA,
    input  logic [NDATA-1:0]            doutSigB,
    input  logic [NDATA-1:0]            doutSigC,
    output logic                        busy,
    output logic                        valid,
    output logic [DIST_W(NDATA)-1:0]    distA,
    output logic [DIST_W(NDATA)-1:0]    distB,
    output logic [DIST_W(NDATA)-1:0]    distC,
    output logic [1:0]                  best,
`ifdef SSL_MATCH_VOTE_EN
    output logic [NDATA-1:0]            doutVote,
    output logic [DIST_W(NDATA)-1:0]    voteFix,
`endif
    output logic                        match
);

    localparam int DW      = DIST_W(NDATA);
    localparam int PW      = DIST_W(NCHUNK);
    localparam int NCHUNKS = NDATA / NCHUNK;
    localparam int KW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q;
    logic              snap_en, scan_en, load_out, last_chunk;

    logic [NDATA-1:0]  snap_ref, snap_a, snap_b, snap_c;
    logic [DW-1:0]     acc_a, acc_b, acc_c;
    logic [DW-1:0]     sum_a, sum_b, sum_c;
    logic [NCHUNK-1:0] ref_c, a_c, b_c, c_c;
    logic [PW-1:0]     pc_a, pc_b, pc_c;
    logic [1:0]        best_d;
    logic [DW-1:0]     min_d;
    logic              match_d;

    assign last_chunk = (k_q == KW'(NCHUNKS - 1));
    assign busy       = (state_q != IDLE);
    assign valid      = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d  = state_q;
        snap_en  = 1'b0;
        scan_en  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && start) begin
                    snap_en = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ena) begin
                    scan_en = 1'b1;
                    if (last_chunk) begin
                        load_out = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (ena) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the current chunk of each snapshot.
    always_comb begin
        ref_c = snap_ref[k_q*NCHUNK +: NCHUNK];
        a_c   = snap_a[k_q*NCHUNK +: NCHUNK];
        b_c   = snap_b[k_q*NCHUNK +: NCHUNK];
        c_c   = snap_c[k_q*NCHUNK +: NCHUNK];
    end

    ssl_popcnt #(.W(NCHUNK)) u_pc_a (.bits(ref_c ^ a_c), .count(pc_a));
    ssl_popcnt #(.W(NCHUNK)) u_pc_b (.bits(ref_c ^ b_c), .count(pc_b));
    ssl_popcnt #(.W(NCHUNK)) u_pc_c (.bits(ref_c ^ c_c), .count(pc_c));

    assign sum_a = acc_a + DW'(pc_a);
    assign sum_b = acc_b + DW'(pc_b);
    assign sum_c = acc_c + DW'(pc_c);

    // Closest signature on the running sums; ties keep the lower index.
    always_comb begin
        if ((sum_a <= sum_b) && (sum_a <= sum_c)) begin
            best_d = SEL_A;
            min_d  = sum_a;
        end else if (sum_b <= sum_c) begin
            best_d = SEL_B;
            min_d  = sum_b;
        end else begin
            best_d = SEL_C;
            min_d  = sum_c;
        end
        match_d = (min_d <= DW'(THRESH));
    end

    // Snapshot inputs on accept, then accumulate one chunk per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_ref <= '0;
            snap_a   <= '0;
            snap_b   <= '0;
            snap_c   <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            acc_c    <= '0;
            k_q      <= '0;
        end else if (snap_en) begin
            snap_ref <= doutRef;
            snap_a   <= doutSigA;
            snap_b   <= doutSigB;
            snap_c   <= doutSigC;
            acc_a    <= '0;
            acc_b    <= '0;
            acc_c    <= '0;
            k_q      <= '0;
        end else if (scan_en) begin
            acc_a <= sum_a;
            acc_b <= sum_b;
            acc_c <= sum_c;
            k_q   <= last_chunk ? '0 : k_q + 1'b1;
        end
    end

    // Results are loaded from the final-chunk sums on entry to DONE, so they
    // are already stable while valid is high during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            distA <= '0;
            distB <= '0;
            distC <= '0;
            best  <= SEL_A;
            match <= 1'b0;
        end else if (load_out) begin
            distA <= sum_a;
            distB <= sum_b;
            distC <= sum_c;
            best  <= best_d;
            match <= match_d;
        end
    end

`ifdef SSL_MATCH_VOTE_EN
    logic [NCHUNK-1:0] maj_c;
    logic [PW-1:0]     pc_v;
    logic [NDATA-1:0]  vote_acc, vote_next;
    logic [DW-1:0]     vfix_acc, vfix_sum;

    assign maj_c    = (a_c & b_c) | (a_c & c_c) | (b_c & c_c);
    assign vfix_sum = vfix_acc + DW'(pc_v);

    ssl_popcnt #(.W(NCHUNK)) u_pc_v (.bits(ref_c ^ maj_c), .count(pc_v));

    // Merge the current majority chunk into the partially built vote word.
    always_comb begin
        vote_next = vote_acc;
        vote_next[k_q*NCHUNK +: NCHUNK] = maj_c;
    end

    // Build the vote word and its distance chunk by chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_acc <= '0;
            vfix_acc <= '0;
        end else if (snap_en) begin
            vote_acc <= '0;
            vfix_acc <= '0;
        end else if (scan_en) begin
            vote_acc <= vote_next;
            vfix_acc <= vfix_sum;
        end
    end

    // Publish the vote results alongside the distances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            doutVote <= '0;
            voteFix  <= '0;
        end else if (load_out) begin
            doutVote <= vote_next;
            voteFix  <= vfix_sum;
        end
    end
`endif

endmodule
